// File: rtl/spi_frame_slave_rx.sv
// SPI mode-0 slave receiver: deserialises MSB-first bytes into fixed-size frames
// and commits them to a ping-pong buffer whose read bank only changes on a full frame.
`timescale 1ns/1ps
module spi_frame_slave_rx #(
    parameter int FRAME_BYTES  = 16,
    parameter int ADDR_W       = 4,
    parameter int TIMEOUT_CLKS = 4096
) (
    input  logic              i_Clk,
    input  logic              i_Rst_L,
    input  logic              i_SPI_Clk,
    input  logic              i_SPI_MOSI,
    input  logic              i_SPI_CS_n,
    output logic              o_RX_DV,
    output logic [7:0]        o_RX_Byte,
    output logic              o_Frame_Valid,
    output logic              o_Frame_Err,
    output logic [ADDR_W:0]   o_Byte_Idx,
    input  logic [ADDR_W-1:0] i_Rd_Addr,
    output logic [7:0]        o_Rd_Data
);

    localparam int IW   = ADDR_W + 1;
    localparam int TO_W = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [IW-1:0]   LAST_IDX = IW'(FRAME_BYTES - 1);
    localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CLKS - 1);

    typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

    state_t          state, state_next;
    logic [1:0]      sclk_sync, mosi_sync, cs_sync;
    logic            sclk_prev, cs_prev;
    logic            sclk_rise, cs_fall, cs_rise;
    logic [2:0]      bit_cnt;
    logic [6:0]      shift_reg;
    logic [7:0]      rx_byte_next;
    logic [IW-1:0]   byte_idx;
    logic [TO_W-1:0] timeout_cnt;
    logic            wr_bank, rd_bank;
    logic            start_byte, shift_en, byte_done, frame_done, partial_abort, timeout_hit;
    logic [7:0]      mem [0:2*FRAME_BYTES-1];

    // CS_n synchroniser resets high so release of reset never looks like a CS fall
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            sclk_sync <= 2'b00;
            mosi_sync <= 2'b00;
            cs_sync   <= 2'b11;
            sclk_prev <= 1'b0;
            cs_prev   <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[0], i_SPI_Clk};
            mosi_sync <= {mosi_sync[0], i_SPI_MOSI};
            cs_sync   <= {cs_sync[0], i_SPI_CS_n};
            sclk_prev <= sclk_sync[1];
            cs_prev   <= cs_sync[1];
        end
    end

    assign sclk_rise    = sclk_sync[1] & ~sclk_prev;
    assign cs_fall      = ~cs_sync[1] & cs_prev;
    assign cs_rise      = cs_sync[1] & ~cs_prev;
    assign rx_byte_next = {shift_reg, mosi_sync[1]};
    assign o_Byte_Idx   = byte_idx;

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) state <= ST_IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next    = state;
        start_byte    = 1'b0;
        shift_en      = 1'b0;
        byte_done     = 1'b0;
        frame_done    = 1'b0;
        partial_abort = 1'b0;
        timeout_hit   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cs_fall) begin
                    state_next = ST_SHIFT;
                    start_byte = 1'b1;
                end else if (byte_idx != '0 && timeout_cnt == TO_LAST) begin
                    timeout_hit = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (cs_rise) begin
                    state_next    = ST_IDLE;
                    partial_abort = (bit_cnt != 3'd0);
                end else if (sclk_rise) begin
                    shift_en   = 1'b1;
                    byte_done  = (bit_cnt == 3'd7);
                    frame_done = (bit_cnt == 3'd7) && (byte_idx == LAST_IDX);
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // bit_cnt wraps 7->0 on the eighth bit, so back-to-back bytes in one CS window need no extra handling
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            bit_cnt       <= 3'd0;
            shift_reg     <= 7'd0;
            byte_idx      <= '0;
            timeout_cnt   <= '0;
            wr_bank       <= 1'b0;
            rd_bank       <= 1'b1;
            o_RX_DV       <= 1'b0;
            o_RX_Byte     <= 8'd0;
            o_Frame_Valid <= 1'b0;
            o_Frame_Err   <= 1'b0;
        end else begin
            o_RX_DV       <= byte_done;
            o_Frame_Valid <= frame_done;
            o_Frame_Err   <= partial_abort | timeout_hit;
            if (start_byte) begin
                bit_cnt     <= 3'd0;
                timeout_cnt <= '0;
            end else if (state == ST_IDLE && byte_idx != '0) begin
                timeout_cnt <= timeout_hit ? '0 : timeout_cnt + TO_W'(1);
            end
            if (shift_en) begin
                shift_reg <= rx_byte_next[6:0];
                bit_cnt   <= bit_cnt + 3'd1;
            end
            if (partial_abort) bit_cnt <= 3'd0;
            if (byte_done) o_RX_Byte <= rx_byte_next;
            if (frame_done) begin
                byte_idx <= '0;
                wr_bank  <= ~wr_bank;
                rd_bank  <= ~rd_bank;
            end else if (byte_done) begin
                byte_idx <= byte_idx + IW'(1);
            end else if (partial_abort || timeout_hit) begin
                byte_idx <= '0;
            end
        end
    end

    always_ff @(posedge i_Clk) begin
        if (byte_done) mem[{wr_bank, byte_idx[ADDR_W-1:0]}] <= rx_byte_next;
    end

    // rd_bank is the pre-swap value here, so a read landing on the commit cycle sees the old frame
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) o_Rd_Data <= 8'd0;
        else          o_Rd_Data <= mem[{rd_bank, i_Rd_Addr}];
    end

endmodule

// File: tb/tb_spi_frame_slave_rx.sv
// Self-checking bench for spi_frame_slave_rx: directed SPI scenarios plus random frames,
// checked against a frame-level model of the committed read bank.
`timescale 1ns/1ps
module tb_spi_frame_slave_rx;

    localparam int FRAME_BYTES  = 16;
    localparam int ADDR_W       = 4;
    localparam int TIMEOUT_CLKS = 4096;

    logic              i_Clk;
    logic              i_Rst_L;
    logic              i_SPI_Clk;
    logic              i_SPI_MOSI;
    logic              i_SPI_CS_n;
    logic              o_RX_DV;
    logic [7:0]        o_RX_Byte;
    logic              o_Frame_Valid;
    logic              o_Frame_Err;
    logic [ADDR_W:0]   o_Byte_Idx;
    logic [ADDR_W-1:0] i_Rd_Addr;
    logic [7:0]        o_Rd_Data;

    spi_frame_slave_rx #(
        .FRAME_BYTES (FRAME_BYTES),
        .ADDR_W      (ADDR_W),
        .TIMEOUT_CLKS(TIMEOUT_CLKS)
    ) dut (
        .i_Clk        (i_Clk),
        .i_Rst_L      (i_Rst_L),
        .i_SPI_Clk    (i_SPI_Clk),
        .i_SPI_MOSI   (i_SPI_MOSI),
        .i_SPI_CS_n   (i_SPI_CS_n),
        .o_RX_DV      (o_RX_DV),
        .o_RX_Byte    (o_RX_Byte),
        .o_Frame_Valid(o_Frame_Valid),
        .o_Frame_Err  (o_Frame_Err),
        .o_Byte_Idx   (o_Byte_Idx),
        .i_Rd_Addr    (i_Rd_Addr),
        .o_Rd_Data    (o_Rd_Data)
    );

    initial i_Clk = 1'b0;
    always #5 i_Clk = ~i_Clk;

    int tests_run    = 0;
    int tests_failed = 0;
    int spi_half     = 8;
    int cycle_cnt    = 0;
    int cs_high_cycle = 0;

    int dv_count = 0, fv_count = 0, fv_with_dv = 0, err_count = 0, both_count = 0, err_cycle = 0;
    int snap_dv, snap_fv, snap_fvd, snap_err;
    logic [7:0] rd_at_fv, rd_after_fv;
    bit         fv_pending = 1'b0;
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];

    logic [7:0] model_bank[FRAME_BYTES];
    logic [7:0] model_cur[$];
    logic [7:0] tx_frame[FRAME_BYTES];

    always @(posedge i_Clk) cycle_cnt++;

    // Passive observer: records strobes and the read data around each commit
    always @(negedge i_Clk) begin
        if (i_Rst_L) begin
            if (fv_pending) begin
                rd_after_fv = o_Rd_Data;
                fv_pending  = 1'b0;
            end
            if (o_RX_DV) begin
                dv_count++;
                rx_q.push_back(o_RX_Byte);
            end
            if (o_Frame_Valid) begin
                fv_count++;
                if (o_RX_DV) fv_with_dv++;
                rd_at_fv   = o_Rd_Data;
                fv_pending = 1'b1;
            end
            if (o_Frame_Err) begin
                err_count++;
                err_cycle = cycle_cnt;
                if (o_Frame_Valid) both_count++;
            end
        end
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic model_accept(input logic [7:0] b);
        exp_q.push_back(b);
        model_cur.push_back(b);
        if (model_cur.size() == FRAME_BYTES) begin
            for (int i = 0; i < FRAME_BYTES; i++) model_bank[i] = model_cur[i];
            model_cur.delete();
        end
    endtask

    task automatic spi_bit(input logic b);
        i_SPI_MOSI = b;
        repeat (spi_half) @(negedge i_Clk);
        i_SPI_Clk = 1'b1;
        repeat (spi_half) @(negedge i_Clk);
        i_SPI_Clk = 1'b0;
    endtask

    task automatic shift_bits(input logic [7:0] b, input int nbits);
        for (int i = 0; i < nbits; i++) spi_bit(b[7-i]);
    endtask

    task automatic cs_low();
        @(negedge i_Clk);
        i_SPI_CS_n = 1'b0;
        repeat (4) @(negedge i_Clk);
    endtask

    task automatic cs_high();
        repeat (4) @(negedge i_Clk);
        i_SPI_CS_n    = 1'b1;
        cs_high_cycle = cycle_cnt;
        repeat (6) @(negedge i_Clk);
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        cs_low();
        shift_bits(b, 8);
        model_accept(b);
        cs_high();
    endtask

    task automatic send_frame_toggled();
        for (int i = 0; i < FRAME_BYTES; i++) applyStimulus(tx_frame[i]);
    endtask

    task automatic send_frame_window();
        cs_low();
        for (int i = 0; i < FRAME_BYTES; i++) begin
            shift_bits(tx_frame[i], 8);
            model_accept(tx_frame[i]);
        end
        cs_high();
    endtask

    task automatic snapshot();
        snap_dv  = dv_count;
        snap_fv  = fv_count;
        snap_fvd = fv_with_dv;
        snap_err = err_count;
    endtask

    task automatic check_rx_stream(input string tag);
        checkOutput($sformatf("%s_rx_count", tag), rx_q.size(), exp_q.size());
        for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++)
            checkOutput($sformatf("%s_rx_byte%0d", tag, i), rx_q[i], exp_q[i]);
        rx_q.delete();
        exp_q.delete();
    endtask

    task automatic check_read_bank(input string tag);
        for (int a = 0; a < FRAME_BYTES; a++) begin
            @(negedge i_Clk);
            i_Rd_Addr = ADDR_W'(a);
            @(negedge i_Clk);
            checkOutput($sformatf("%s_rd%0d", tag, a), o_Rd_Data, model_bank[a]);
        end
    endtask

    task automatic check_frame(input string tag);
        checkOutput($sformatf("%s_dv_pulses", tag), dv_count - snap_dv, FRAME_BYTES);
        checkOutput($sformatf("%s_frame_valid", tag), fv_count - snap_fv, 1);
        checkOutput($sformatf("%s_valid_with_dv", tag), fv_with_dv - snap_fvd, 1);
        checkOutput($sformatf("%s_no_err", tag), err_count - snap_err, 0);
        checkOutput($sformatf("%s_byte_idx", tag), o_Byte_Idx, 0);
        check_rx_stream(tag);
        check_read_bank(tag);
    endtask

    task automatic check_all_zero(input string tag);
        checkOutput($sformatf("%s_rx_dv", tag), o_RX_DV, 0);
        checkOutput($sformatf("%s_rx_byte", tag), o_RX_Byte, 0);
        checkOutput($sformatf("%s_frame_valid", tag), o_Frame_Valid, 0);
        checkOutput($sformatf("%s_frame_err", tag), o_Frame_Err, 0);
        checkOutput($sformatf("%s_byte_idx", tag), o_Byte_Idx, 0);
        checkOutput($sformatf("%s_rd_data", tag), o_Rd_Data, 0);
    endtask

    initial begin
        int         delta;
        logic [7:0] old3;
        logic [7:0] b;

        i_Rst_L    = 1'b0;
        i_SPI_Clk  = 1'b0;
        i_SPI_MOSI = 1'b0;
        i_SPI_CS_n = 1'b1;
        i_Rd_Addr  = '0;
        repeat (3) @(negedge i_Clk);
        check_all_zero("reset");
        i_Rst_L = 1'b1;
        repeat (4) @(negedge i_Clk);

        $display("[TB] test 1: incrementing frame, CS per byte");
        for (int i = 0; i < FRAME_BYTES; i++) tx_frame[i] = 8'(i);
        snapshot();
        send_frame_toggled();
        @(negedge i_Clk);
        i_Rd_Addr = 4'd5;
        @(negedge i_Clk);
        checkOutput("t1_addr5", o_Rd_Data, 8'h05);
        check_frame("t1");

        $display("[TB] test 2: bank swap timing");
        for (int i = 0; i < FRAME_BYTES; i++) tx_frame[i] = 8'hA0 + 8'(i);
        snapshot();
        send_frame_toggled();
        check_frame("t2a");
        old3 = model_bank[3];
        @(negedge i_Clk);
        i_Rd_Addr = 4'd3;
        @(negedge i_Clk);
        checkOutput("t2_before_b", o_Rd_Data, old3);
        for (int i = 0; i < FRAME_BYTES; i++) tx_frame[i] = 8'hB0 + 8'(i);
        snapshot();
        for (int i = 0; i < FRAME_BYTES / 2; i++) applyStimulus(tx_frame[i]);
        checkOutput("t2_mid_b", o_Rd_Data, old3);
        for (int i = FRAME_BYTES / 2; i < FRAME_BYTES; i++) applyStimulus(tx_frame[i]);
        checkOutput("t2_rd_in_valid_cycle", rd_at_fv, old3);
        checkOutput("t2_rd_after_valid", rd_after_fv, model_bank[3]);
        check_frame("t2b");

        $display("[TB] test 3: partial byte abort");
        snapshot();
        for (int i = 0; i < 3; i++) applyStimulus(8'($urandom));
        cs_low();
        shift_bits(8'($urandom), 5);
        cs_high();
        model_cur.delete();
        checkOutput("t3_err", err_count - snap_err, 1);
        checkOutput("t3_dv", dv_count - snap_dv, 3);
        checkOutput("t3_no_valid", fv_count - snap_fv, 0);
        checkOutput("t3_byte_idx", o_Byte_Idx, 0);
        check_rx_stream("t3");
        for (int i = 0; i < FRAME_BYTES; i++) tx_frame[i] = 8'($urandom);
        snapshot();
        send_frame_toggled();
        check_frame("t3_next");

        $display("[TB] test 4: mid-frame timeout");
        snapshot();
        for (int i = 0; i < 7; i++) applyStimulus(8'($urandom));
        checkOutput("t4_idx7", o_Byte_Idx, 7);
        for (int i = 0; i < TIMEOUT_CLKS + 200 && err_count == snap_err; i++) @(negedge i_Clk);
        model_cur.delete();
        delta = err_cycle - cs_high_cycle;
        $display("[TB] timeout strobe %0d cycles after CS_n rose", delta);
        checkOutput("t4_err", err_count - snap_err, 1);
        checkOutput("t4_err_latency_in_window",
                    32'((delta >= TIMEOUT_CLKS) && (delta <= TIMEOUT_CLKS + 4)), 1);
        checkOutput("t4_no_valid", fv_count - snap_fv, 0);
        checkOutput("t4_byte_idx", o_Byte_Idx, 0);
        check_rx_stream("t4");
        check_read_bank("t4_unchanged");

        $display("[TB] test 5: reset mid-frame");
        for (int i = 0; i < 10; i++) applyStimulus(8'h80 | 8'($urandom));
        checkOutput("t5_idx10", o_Byte_Idx, 10);
        check_rx_stream("t5_pre");
        cs_low();
        shift_bits(8'($urandom), 3);
        i_SPI_MOSI = 1'b1;
        repeat (spi_half / 2) @(negedge i_Clk);
        #2 i_Rst_L = 1'b0;
        #1 check_all_zero("t5_async_reset");
        model_cur.delete();
        i_SPI_Clk  = 1'b0;
        i_SPI_CS_n = 1'b1;
        repeat (5) @(negedge i_Clk);
        i_Rst_L = 1'b1;
        repeat (5) @(negedge i_Clk);
        for (int i = 0; i < FRAME_BYTES; i++) tx_frame[i] = 8'h5A;
        snapshot();
        send_frame_toggled();
        check_frame("t5_post");

        $display("[TB] test 6: whole frame in one CS window");
        for (int i = 0; i < FRAME_BYTES; i++) tx_frame[i] = 8'(i);
        snapshot();
        send_frame_window();
        check_frame("t6");

        $display("[TB] test 7: random frames and SCLK rates");
        for (int f = 0; f < 2; f++) begin
            spi_half = $urandom_range(5, 10);
            for (int i = 0; i < FRAME_BYTES; i++) tx_frame[i] = 8'($urandom);
            snapshot();
            if ($urandom_range(0, 1) == 1) send_frame_window();
            else                           send_frame_toggled();
            check_frame($sformatf("t7_f%0d", f));
        end

        b = 8'(both_count);
        checkOutput("never_err_and_valid", b, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
